// File: rtl/trig_ddr_tx_framer.sv
// DDR trigger-link transmit framer: 2-bit sync header + payload, two bits per clock to an ODDR.
// Optional macro TX_PRBS_IDLE_EN fills idle payload with PRBS-7 instead of zeros.
module trig_ddr_tx_framer #(
  parameter int WORD_WIDTH   = 16,
  parameter int TRAIN_CYCLES = 1024,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  train_req,
  input  logic [WORD_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  d0,
  output logic                  d1,
  output logic                  training,
  output logic                  frame_start,
  output logic [CNT_WIDTH-1:0]  frame_cnt
);

  localparam int NB = WORD_WIDTH / 2;
  localparam int BW = $clog2(NB + 1);
  localparam int TW = $clog2(TRAIN_CYCLES);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(NB);
  localparam logic [TW-1:0] LAST_TRAIN = TW'(TRAIN_CYCLES - 1);

  typedef enum logic {TRAIN, SEND} state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   tcnt, tcnt_nx;
  logic [BW-1:0]   beat, beat_nx;
  logic            train_pending, pending_nx;
  logic [WORD_WIDTH-1:0] sreg;
  logic            is_data;
  logic            load, take;
  logic            d0_nx, d1_nx, fs_nx, trn_nx, cnt_inc;
`ifdef TX_PRBS_IDLE_EN
  logic [6:0]      lfsr;
  logic            prbs_adv;
`endif

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= TRAIN;
      tcnt          <= '0;
      beat          <= '0;
      train_pending <= 1'b0;
    end else begin
      state         <= state_nx;
      tcnt          <= tcnt_nx;
      beat          <= beat_nx;
      train_pending <= pending_nx;
    end
  end

  // next state
  always_comb begin
    state_nx   = state;
    tcnt_nx    = tcnt;
    beat_nx    = beat;
    pending_nx = train_pending;
    case (state)
      TRAIN: begin
        if (train_req)               tcnt_nx = '0;
        else if (tcnt == LAST_TRAIN) begin
          state_nx = SEND;
          tcnt_nx  = '0;
          beat_nx  = '0;
        end else                     tcnt_nx = tcnt + TW'(1);
      end
      default: begin
        if (beat == LAST_BEAT) begin
          // a request arriving in the load cycle itself also ends the frame into training
          if (train_pending || train_req) begin
            state_nx   = TRAIN;
            tcnt_nx    = '0;
            pending_nx = 1'b0;
          end
          beat_nx = '0;
        end else begin
          beat_nx = beat + BW'(1);
          if (train_req) pending_nx = 1'b1;
        end
      end
    endcase
  end

  // outputs: handshake plus next values of the registered wire outputs
  always_comb begin
    load      = (state == TRAIN) ? (tcnt == LAST_TRAIN && !train_req) : (beat == LAST_BEAT);
    din_ready = load && !train_pending && !train_req;
    take      = din_valid && din_ready;
    d0_nx     = 1'b1;
    d1_nx     = 1'b0;
    fs_nx     = 1'b0;
    trn_nx    = 1'b1;
    cnt_inc   = 1'b0;
`ifdef TX_PRBS_IDLE_EN
    prbs_adv  = 1'b0;
`endif
    if (state == SEND) begin
      trn_nx = 1'b0;
      if (beat == '0) begin
        fs_nx   = 1'b1;
        d0_nx   = !is_data;
        d1_nx   = is_data;
        cnt_inc = is_data;
      end else if (is_data) begin
        d0_nx = sreg[0];
        d1_nx = sreg[1];
      end else begin
`ifdef TX_PRBS_IDLE_EN
        d0_nx    = lfsr[6];
        d1_nx    = lfsr[5];
        prbs_adv = 1'b1;
`else
        d0_nx = 1'b0;
        d1_nx = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg    <= '0;
      is_data <= 1'b0;
    end else if (load) begin
      sreg    <= take ? din : '0;
      is_data <= take;
    end else if (state == SEND && beat != '0) begin
      sreg    <= sreg >> 2;
    end
  end

`ifdef TX_PRBS_IDLE_EN
  // x^7+x^6+1, two steps per idle payload beat; lfsr[6] is the older bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         lfsr <= 7'h7F;
    else if (prbs_adv) lfsr <= {lfsr[4:0], lfsr[6] ^ lfsr[5], lfsr[5] ^ lfsr[4]};
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d0          <= 1'b1;
      d1          <= 1'b0;
      training    <= 1'b1;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      d0          <= d0_nx;
      d1          <= d1_nx;
      training    <= trn_nx;
      frame_start <= fs_nx;
      if (cnt_inc) frame_cnt <= frame_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_trig_ddr_tx_framer.sv
// Directed, table-driven bench for trig_ddr_tx_framer (WORD_WIDTH=16, TRAIN_CYCLES=8).
module tb_trig_ddr_tx_framer;
  localparam int WW = 16;
  localparam int TC = 8;
  localparam int CW = 16;
  localparam int NB = WW / 2;

  logic clock = 1'b0;
  logic reset, train_req, din_valid;
  logic [WW-1:0] din;
  logic din_ready, d0, d1, training, frame_start;
  logic [CW-1:0] frame_cnt;

  always #5 clock = ~clock;

  trig_ddr_tx_framer #(.WORD_WIDTH(WW), .TRAIN_CYCLES(TC), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .train_req(train_req), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .d0(d0), .d1(d1), .training(training),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  // one record per clock: inputs for the cycle, din_ready expected before the edge,
  // wire outputs expected just after the edge
  typedef struct {
    logic tr; logic dv; logic [WW-1:0] din;
    logic e0, e1, efs, etrn, erdy; logic [CW-1:0] ecnt;
  } vec_t;

  vec_t vq[$];
  int   n_chk = 0, n_fail = 0;
  int   ecnt;
`ifdef TX_PRBS_IDLE_EN
  logic pb[127];
  int   pi;
`endif

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic push(input logic tr, input logic dv, input logic [WW-1:0] w,
                      input logic e0, input logic e1, input logic efs, input logic etrn, input logic erdy);
    vec_t v;
    v.tr = tr; v.dv = dv; v.din = w;
    v.e0 = e0; v.e1 = e1; v.efs = efs; v.etrn = etrn; v.erdy = erdy;
    v.ecnt = CW'(ecnt);
    vq.push_back(v);
  endtask

  // training period; reload_at >= 0 raises train_req at that count, restarting it
  task automatic add_train(input int reload_at, input logic dv, input logic [WW-1:0] w);
    int total;
    total = (reload_at >= 0) ? reload_at + 1 + TC : TC;
    for (int i = 0; i < total; i++)
      push(i == reload_at, dv, w, 1'b1, 1'b0, 1'b0, 1'b1, i == total - 1);
  endtask

  task automatic add_frame(input logic data, input logic [WW-1:0] w, input int nbeats, input logic tr3,
                           input logic ndv, input logic [WW-1:0] ndin, input logic rdy_last);
    logic e0, e1;
    for (int b = 0; b < nbeats; b++) begin
      if (b == 0) begin
        e0 = !data; e1 = data;
        if (data) ecnt++;
      end else if (data) begin
        e0 = w[2*b-2]; e1 = w[2*b-1];
      end else begin
`ifdef TX_PRBS_IDLE_EN
        e0 = pb[pi % 127]; e1 = pb[(pi + 1) % 127]; pi += 2;
`else
        e0 = 1'b0; e1 = 1'b0;
`endif
      end
      push(tr3 && b == 3, ndv, ndin, e0, e1, b == 0, 1'b0, (b == NB) ? rdy_last : 1'b0);
    end
  endtask

  task automatic run_vecs();
    foreach (vq[i]) begin
      train_req = vq[i].tr; din_valid = vq[i].dv; din = vq[i].din;
      #1;
      chk("din_ready", i, 32'(din_ready), 32'(vq[i].erdy));
      @(posedge clock); #1;
      chk("d0", i, 32'(d0), 32'(vq[i].e0));
      chk("d1", i, 32'(d1), 32'(vq[i].e1));
      chk("frame_start", i, 32'(frame_start), 32'(vq[i].efs));
      chk("training", i, 32'(training), 32'(vq[i].etrn));
      chk("frame_cnt", i, 32'(frame_cnt), 32'(vq[i].ecnt));
    end
    vq.delete();
  endtask

  initial begin
`ifdef TX_PRBS_IDLE_EN
    // reference PRBS-7 bit stream: b[n] = b[n-7] ^ b[n-6], seed all ones
    for (int i = 0; i < 127; i++) pb[i] = (i < 7) ? 1'b1 : (pb[i-7] ^ pb[i-6]);
    pi = 0;
`endif
    reset = 1'b1; train_req = 1'b0; din_valid = 1'b0; din = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_d0", 0, 32'(d0), 32'd1);
    chk("rst_d1", 0, 32'(d1), 32'd0);
    chk("rst_training", 0, 32'(training), 32'd1);
    chk("rst_frame_start", 0, 32'(frame_start), 32'd0);
    chk("rst_frame_cnt", 0, 32'(frame_cnt), 32'd0);
    chk("rst_din_ready", 0, 32'(din_ready), 32'd0);
    reset = 1'b0;

    // training, idle frame, A5C3, four back-to-back words, idle, train_req mid-frame,
    // restarted training, data, then a partial frame cut by reset
    ecnt = 0;
    add_train(-1, 1'b0, '0);
    add_frame(1'b0, '0,         NB + 1, 1'b0, 1'b1, 16'hA5C3, 1'b1);
    add_frame(1'b1, 16'hA5C3,   NB + 1, 1'b0, 1'b1, 16'h1001, 1'b1);
    add_frame(1'b1, 16'h1001,   NB + 1, 1'b0, 1'b1, 16'h2002, 1'b1);
    add_frame(1'b1, 16'h2002,   NB + 1, 1'b0, 1'b1, 16'h3003, 1'b1);
    add_frame(1'b1, 16'h3003,   NB + 1, 1'b0, 1'b1, 16'h4004, 1'b1);
    add_frame(1'b1, 16'h4004,   NB + 1, 1'b0, 1'b0, 16'h0000, 1'b1);
    add_frame(1'b0, '0,         NB + 1, 1'b0, 1'b1, 16'h5A5A, 1'b1);
    add_frame(1'b1, 16'h5A5A,   NB + 1, 1'b1, 1'b1, 16'hDEAD, 1'b0);
    add_train(3, 1'b1, 16'hDEAD);
    add_frame(1'b1, 16'hDEAD,   NB + 1, 1'b0, 1'b1, 16'h0080, 1'b1);
    add_frame(1'b1, 16'h0080,   5,      1'b0, 1'b1, 16'h0080, 1'b0);
    run_vecs();

    // state is now at beat 5; reset must act without waiting for an edge
    #2;
    reset = 1'b1;
    #1;
    chk("arst_d0", 1, 32'(d0), 32'd1);
    chk("arst_d1", 1, 32'(d1), 32'd0);
    chk("arst_training", 1, 32'(training), 32'd1);
    chk("arst_frame_start", 1, 32'(frame_start), 32'd0);
    chk("arst_frame_cnt", 1, 32'(frame_cnt), 32'd0);
    chk("arst_din_ready", 1, 32'(din_ready), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; din_valid = 1'b0;

    // after reset only idle frames follow: the cut word is never re-sent
    ecnt = 0;
`ifdef TX_PRBS_IDLE_EN
    pi = 0;
`endif
    add_train(-1, 1'b0, '0);
    add_frame(1'b0, '0, NB + 1, 1'b0, 1'b0, '0, 1'b1);
    add_frame(1'b0, '0, NB + 1, 1'b0, 1'b0, '0, 1'b1);
    run_vecs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
